// File: rtl/debounce.sv
`default_nettype none
// ============================================================================
//  Module      : debounce
//  Description : Push-button debouncer on a single system clock. The raw
//                button is synchronised through two flops, sampled on a
//                clock-enable tick every TICK_DIV cycles, and accepted as a
//                new level only after STABLE_TICKS consecutive samples that
//                differ from the current level. A registered one-cycle pulse
//                marks each accepted press.
//
//  Ports       : src_clk  - system clock, all logic on its rising edge
//                rst      - synchronous active-high reset
//                pb_1     - raw asynchronous push-button (1 = pressed)
//                pb_out   - one-cycle pulse, the cycle after pb_level rises
//                pb_level - debounced button level
//
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce #(
    parameter int TICK_DIV     = 4,
    parameter int STABLE_TICKS = 3,
    parameter int CNT_W        = 16
) (
    input  logic src_clk,
    input  logic rst,
    input  logic pb_1,
    output logic pb_out,
    output logic pb_level
);

    localparam int                SCNT_W      = $clog2(STABLE_TICKS) + 1;
    localparam logic [CNT_W-1:0]  C_TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [SCNT_W-1:0] C_SCNT_LAST = SCNT_W'(STABLE_TICKS - 1);

    logic              r_s0_q;
    logic              r_s1_q;
    logic [CNT_W-1:0]  r_tcnt_q;
    logic [SCNT_W-1:0] r_scnt_q;
    logic [SCNT_W-1:0] w_scnt_d;
    logic              r_level_q;
    logic              w_level_d;
    logic              r_level_prev_q;
    logic              r_out_q;
    logic              w_tick;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; only r_s1_q reaches the filter.
    // ------------------------------------------------------------------
    always_ff @(posedge src_clk) begin
        if (rst) begin
            r_s0_q <= 1'b0;
            r_s1_q <= 1'b0;
        end else begin
            r_s0_q <= pb_1;
            r_s1_q <= r_s0_q;
        end
    end

    // ------------------------------------------------------------------
    // Sample tick: counter wraps at TICK_DIV-1. With TICK_DIV=1 the
    // counter stays at zero and the tick is permanently asserted.
    // ------------------------------------------------------------------
    assign w_tick = (r_tcnt_q == C_TICK_LAST);

    always_ff @(posedge src_clk) begin
        if (rst) begin
            r_tcnt_q <= '0;
        end else if (w_tick) begin
            r_tcnt_q <= '0;
        end else begin
            r_tcnt_q <= r_tcnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stability filter. Any sample matching the current level restarts
    // the count, so only an unbroken run of STABLE_TICKS differing
    // samples flips the level.
    // ------------------------------------------------------------------
    always_comb begin
        w_scnt_d  = r_scnt_q;
        w_level_d = r_level_q;
        if (w_tick) begin
            if (r_s1_q == r_level_q) begin
                w_scnt_d = '0;
            end else if (r_scnt_q == C_SCNT_LAST) begin
                w_level_d = r_s1_q;
                w_scnt_d  = '0;
            end else begin
                w_scnt_d = r_scnt_q + SCNT_W'(1);
            end
        end
    end

    always_ff @(posedge src_clk) begin
        if (rst) begin
            r_scnt_q  <= '0;
            r_level_q <= 1'b0;
        end else begin
            r_scnt_q  <= w_scnt_d;
            r_level_q <= w_level_d;
        end
    end

    // ------------------------------------------------------------------
    // Press pulse: edge detect on the registered level, so the pulse
    // appears the cycle after pb_level goes high. Falling edges are
    // ignored.
    // ------------------------------------------------------------------
    always_ff @(posedge src_clk) begin
        if (rst) begin
            r_level_prev_q <= 1'b0;
            r_out_q        <= 1'b0;
        end else begin
            r_level_prev_q <= r_level_q;
            r_out_q        <= r_level_q & ~r_level_prev_q;
        end
    end

    assign pb_level = r_level_q;
    assign pb_out   = r_out_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce
//  Description : Self-checking bench for debounce. A default-parameter
//                instance is exercised with directed press/bounce/release
//                sequences whose expected outcome is queued at stimulus time
//                and compared when the sequence settles. A second instance
//                with TICK_DIV=1, STABLE_TICKS=1 is driven with random input
//                and compared against the input delayed three cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce;

    logic clk;
    logic rst;
    logic pb;
    logic pb_out;
    logic pb_level;

    logic rst2;
    logic pb2;
    logic pb_out2;
    logic pb_level2;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int rise_cyc  = -10;
    int pulse_cnt = 0;
    logic mon_prev_level = 1'b0;
    logic mon_prev_out   = 1'b0;

    typedef struct {
        string tag;
        int    start_pulses;
        int    exp_pulses;
        logic  exp_level;
    } exp_t;

    exp_t exp_q[$];
    logic corner_q[$];

    debounce #(.TICK_DIV(4), .STABLE_TICKS(3), .CNT_W(16)) u_dut (
        .src_clk  (clk),
        .rst      (rst),
        .pb_1     (pb),
        .pb_out   (pb_out),
        .pb_level (pb_level)
    );

    debounce #(.TICK_DIV(1), .STABLE_TICKS(1), .CNT_W(4)) u_dut_fast (
        .src_clk  (clk),
        .rst      (rst2),
        .pb_1     (pb2),
        .pb_out   (pb_out2),
        .pb_level (pb_level2)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Pulse monitor on the default instance: every pulse must sit exactly
    // one cycle after a level rise and last a single cycle.
    always @(negedge clk) begin
        cyc++;
        if (pb_level && !mon_prev_level) rise_cyc = cyc;
        if (pb_out) begin
            pulse_cnt++;
            check_value("pulse_pos", cyc, rise_cyc + 1);
            check_value("pulse_width", {31'd0, mon_prev_out}, 0);
        end
        mon_prev_level = pb_level;
        mon_prev_out   = pb_out;
    end

    task automatic expect_push(input string tag, input int pulses, input logic level);
        exp_t e;
        e.tag          = tag;
        e.start_pulses = pulse_cnt;
        e.exp_pulses   = pulses;
        e.exp_level    = level;
        exp_q.push_back(e);
    endtask

    task automatic expect_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_value("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_value({e.tag, "_pulses"}, pulse_cnt - e.start_pulses, e.exp_pulses);
            check_value({e.tag, "_level"}, {31'd0, pb_level}, {31'd0, e.exp_level});
        end
    endtask

    task automatic wait_level(input logic val, input int budget, input string tag);
        int n = 0;
        while (pb_level !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_value(tag, {31'd0, pb_level}, {31'd0, val});
    endtask

    task automatic hold_cycles(input logic val, input int n);
        pb = val;
        repeat (n) @(negedge clk);
    endtask

    task automatic main_seq();
        // Reset with the button held down.
        rst = 1'b1;
        pb  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_value("rst_level", {31'd0, pb_level}, 0);
            check_value("rst_out", {31'd0, pb_out}, 0);
        end
        expect_push("rst_press", 1, 1'b1);
        rst = 1'b0;
        wait_level(1'b1, 15, "rst_press_rise");
        repeat (10) @(negedge clk);
        expect_pop();

        // Release: level falls, no pulse.
        expect_push("release", 0, 1'b0);
        pb = 1'b0;
        wait_level(1'b0, 14, "release_fall");
        repeat (10) @(negedge clk);
        expect_pop();

        // Clean press held for 40 cycles.
        expect_push("clean_press", 1, 1'b1);
        pb = 1'b1;
        wait_level(1'b1, 14, "clean_rise");
        repeat (26) @(negedge clk);
        expect_pop();

        expect_push("release2", 0, 1'b0);
        pb = 1'b0;
        wait_level(1'b0, 14, "release2_fall");
        repeat (10) @(negedge clk);
        expect_pop();

        // Bounce: 5 ns highs placed between rising edges, then 500 ns low.
        expect_push("bounce", 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            #2 pb = 1'b1;
            #5 pb = 1'b0;
            repeat (2) @(negedge clk);
        end
        hold_cycles(1'b0, 25);
        expect_pop();

        // Short press of two ticks only.
        expect_push("short_press", 0, 1'b0);
        hold_cycles(1'b1, 8);
        hold_cycles(1'b0, 20);
        expect_pop();

        // Press broken by a single low sample: two + two samples never accept.
        expect_push("broken_press", 0, 1'b0);
        hold_cycles(1'b1, 8);
        hold_cycles(1'b0, 4);
        hold_cycles(1'b1, 8);
        hold_cycles(1'b0, 20);
        expect_pop();

        // Same press, now held long enough for three consecutive samples.
        expect_push("long_press", 1, 1'b1);
        hold_cycles(1'b1, 8);
        hold_cycles(1'b0, 4);
        pb = 1'b1;
        wait_level(1'b1, 14, "long_rise");
        repeat (10) @(negedge clk);
        expect_pop();

        pb = 1'b0;
        wait_level(1'b0, 14, "final_fall");
        repeat (4) @(negedge clk);
    endtask

    task automatic corner_seq();
        logic v;
        logic prev1 = 1'b0;
        logic prev2 = 1'b0;
        rst2 = 1'b1;
        pb2  = 1'b0;
        repeat (3) @(negedge clk);
        check_value("c_rst_level", {31'd0, pb_level2}, 0);
        rst2 = 1'b0;
        // Level must equal the input three cycles earlier; the pulse is
        // the rising edge of that delayed level, one cycle later.
        for (int m = 0; m < 64; m++) begin
            if (m > 0) @(negedge clk);
            if (corner_q.size() == 3) begin
                v = corner_q.pop_front();
                check_value("c_level", {31'd0, pb_level2}, {31'd0, v});
                check_value("c_pulse", {31'd0, pb_out2}, {31'd0, prev1 & ~prev2});
                prev2 = prev1;
                prev1 = v;
            end
            pb2 = 1'($urandom_range(0, 1));
            corner_q.push_back(pb2);
        end
        corner_q.delete();

        // Reset in the middle of a held press.
        pb2 = 1'b1;
        repeat (5) @(negedge clk);
        check_value("c_held_level", {31'd0, pb_level2}, 1);
        rst2 = 1'b1;
        @(negedge clk);
        check_value("c_midrst_level", {31'd0, pb_level2}, 0);
        check_value("c_midrst_out", {31'd0, pb_out2}, 0);
        rst2 = 1'b0;
        repeat (3) @(negedge clk);
        check_value("c_repress_level", {31'd0, pb_level2}, 1);
        @(negedge clk);
        check_value("c_repress_out", {31'd0, pb_out2}, 1);
        @(negedge clk);
        check_value("c_repress_out_end", {31'd0, pb_out2}, 0);
    endtask

    initial begin
        rst  = 1'b1;
        pb   = 1'b0;
        rst2 = 1'b1;
        pb2  = 1'b0;
        fork
            main_seq();
            corner_seq();
        join
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
